// File: rtl/vga_ram_arbiter.sv
// Video RAM arbiter: scanout reads win, CPU pixel writes are queued and drained with a starvation guard.
// Optional full-screen clear sweep is compiled in when VGA_ARB_CLEAR_EN is defined.
module vga_ram_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int COLOR_W      = 3,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               Clock,
  input  logic               Reset,
`ifdef VGA_ARB_CLEAR_EN
  input  logic               iClear,
  input  logic [COLOR_W-1:0] iClearColor,
`endif
  input  logic               iCpuWrReq,
  input  logic [7:0]         iCpuRow,
  input  logic [7:0]         iCpuCol,
  input  logic [COLOR_W-1:0] iCpuColor,
  output logic               oCpuBusy,
  input  logic               iVgaRdReq,
  input  logic [7:0]         iVgaRow,
  input  logic [7:0]         iVgaCol,
  output logic [COLOR_W-1:0] oVgaColor,
  output logic               oVgaValid,
  output logic [15:0]        oRamAddr,
  output logic               oRamWe,
  output logic [COLOR_W-1:0] oRamData,
  input  logic [COLOR_W-1:0] iRamData
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int EW = 16 + COLOR_W;
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_IDLE,
    GNT_RD,
    GNT_WR
`ifdef VGA_ARB_CLEAR_EN
    , GNT_CLR
`endif
  } gnt_t;

  gnt_t               gnt_reg, gnt_next;
  logic [CW-1:0]      count_reg;
  logic [PW-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [SW-1:0]      starve_reg, starve_next;
  logic [COLOR_W-1:0] color_reg;
  logic [EW-1:0]      fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]      head;
  logic               busy, push, pop;
  logic [15:0]        ram_addr;
  logic               ram_we;
  logic [COLOR_W-1:0] ram_data;

`ifdef VGA_ARB_CLEAR_EN
  logic               clear_active_reg;
  logic [15:0]        clear_addr_reg;
  logic [COLOR_W-1:0] clear_color_reg;
  assign busy = (count_reg == FULL_CNT) || clear_active_reg;
`else
  assign busy = (count_reg == FULL_CNT);
`endif

  // Push is gated by the registered full flag, so a same-cycle pop never rescues a request.
  assign push = iCpuWrReq && !busy;
  assign pop  = (gnt_next == GNT_WR);
  assign head = fifo_mem[rd_ptr_reg];

  always_comb begin
    gnt_next    = GNT_IDLE;
    ram_addr    = 16'h0000;
    ram_we      = 1'b0;
    ram_data    = '0;
    starve_next = starve_reg;
    if (!Reset) begin
      gnt_next = GNT_IDLE;
    end
`ifdef VGA_ARB_CLEAR_EN
    else if (clear_active_reg) begin
      gnt_next = iVgaRdReq ? GNT_RD : GNT_CLR;
    end
`endif
    else if ((count_reg != '0) && (!iVgaRdReq || (starve_reg == STARVE_SAT))) begin
      gnt_next = GNT_WR;
    end else if (iVgaRdReq) begin
      gnt_next = GNT_RD;
    end

    case (gnt_next)
      GNT_RD: begin
        ram_addr = {iVgaRow, iVgaCol};
      end
      GNT_WR: begin
        ram_addr = head[EW-1:COLOR_W];
        ram_we   = 1'b1;
        ram_data = head[COLOR_W-1:0];
      end
`ifdef VGA_ARB_CLEAR_EN
      GNT_CLR: begin
        ram_addr = clear_addr_reg;
        ram_we   = 1'b1;
        ram_data = clear_color_reg;
      end
`endif
      default: ;
    endcase

    if ((gnt_next == GNT_WR) || (count_reg == '0)) begin
      starve_next = '0;
    end else if ((gnt_next == GNT_RD) && (starve_reg != STARVE_SAT)) begin
      starve_next = starve_reg + SW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      gnt_reg    <= GNT_IDLE;
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      starve_reg <= '0;
      color_reg  <= '0;
    end else begin
      gnt_reg    <= gnt_next;
      starve_reg <= starve_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: ;
      endcase
      if (gnt_reg == GNT_RD) color_reg <= iRamData;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_mem[wr_ptr_reg] <= {iCpuRow, iCpuCol, iCpuColor};
  end

`ifdef VGA_ARB_CLEAR_EN
  // The sweep only advances on cycles scanout left free.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      clear_active_reg <= 1'b0;
      clear_addr_reg   <= 16'h0000;
      clear_color_reg  <= '0;
    end else if (!clear_active_reg) begin
      clear_addr_reg <= 16'h0000;
      if (iClear) begin
        clear_active_reg <= 1'b1;
        clear_color_reg  <= iClearColor;
      end
    end else if (gnt_next == GNT_CLR) begin
      clear_addr_reg <= clear_addr_reg + 16'd1;
      if (clear_addr_reg == 16'hFFFF) clear_active_reg <= 1'b0;
    end
  end
`endif

  // Read data arrives the cycle after the grant; a missed read keeps the last colour.
  assign oVgaValid = (gnt_reg == GNT_RD);
  assign oVgaColor = oVgaValid ? iRamData : color_reg;
  assign oCpuBusy  = busy;
  assign oRamAddr  = ram_addr;
  assign oRamWe    = ram_we;
  assign oRamData  = ram_data;

endmodule

// File: tb/tb_vga_ram_arbiter.sv
// Directed bench for vga_ram_arbiter with a behavioural synchronous video RAM.
module tb_vga_ram_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iClear;
  logic [2:0]  iClearColor;
  logic        iCpuWrReq;
  logic [7:0]  iCpuRow, iCpuCol;
  logic [2:0]  iCpuColor;
  logic        oCpuBusy;
  logic        iVgaRdReq;
  logic [7:0]  iVgaRow, iVgaCol;
  logic [2:0]  oVgaColor;
  logic        oVgaValid;
  logic [15:0] oRamAddr;
  logic        oRamWe;
  logic [2:0]  oRamData;
  logic [2:0]  iRamData;

  logic [2:0]  ram [65536];
  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  vga_ram_arbiter dut (
    .Clock     (Clock),
    .Reset     (Reset),
`ifdef VGA_ARB_CLEAR_EN
    .iClear    (iClear),
    .iClearColor(iClearColor),
`endif
    .iCpuWrReq (iCpuWrReq),
    .iCpuRow   (iCpuRow),
    .iCpuCol   (iCpuCol),
    .iCpuColor (iCpuColor),
    .oCpuBusy  (oCpuBusy),
    .iVgaRdReq (iVgaRdReq),
    .iVgaRow   (iVgaRow),
    .iVgaCol   (iVgaCol),
    .oVgaColor (oVgaColor),
    .oVgaValid (oVgaValid),
    .oRamAddr  (oRamAddr),
    .oRamWe    (oRamWe),
    .oRamData  (oRamData),
    .iRamData  (iRamData)
  );

  // Synchronous RAM, read-before-write, one cycle latency.
  always @(posedge Clock) begin
    if (oRamWe) ram[oRamAddr] <= oRamData;
    iRamData <= ram[oRamAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 3'd0;
    ram[16'h0000] = 3'd7;
    ram[16'h3030] = 3'd5;
    Reset = 1'b0; iClear = 1'b0; iClearColor = 3'd0;
    iCpuWrReq = 1'b0; iCpuRow = 8'h00; iCpuCol = 8'h00; iCpuColor = 3'd0;
    iVgaRdReq = 1'b0; iVgaRow = 8'h00; iVgaCol = 8'h00;

    // reset
    repeat (2) @(posedge Clock);
    @(negedge Clock); #1;
    check("rst_busy",  32'(oCpuBusy),  32'd0);
    check("rst_valid", 32'(oVgaValid), 32'd0);
    check("rst_color", 32'(oVgaColor), 32'd0);
    check("rst_we",    32'(oRamWe),    32'd0);
    check("rst_addr",  32'(oRamAddr),  32'd0);
    check("rst_data",  32'(oRamData),  32'd0);
    $display("txn reset: outputs idle");
    Reset = 1'b1;

    // single scanout read at (0,0)
    @(negedge Clock); iVgaRdReq = 1'b1; iVgaRow = 8'h00; iVgaCol = 8'h00; #1;
    check("rd_addr", 32'(oRamAddr), 32'h0000);
    check("rd_we",   32'(oRamWe),   32'd0);
    @(negedge Clock); iVgaRdReq = 1'b0; #1;
    check("rd_valid", 32'(oVgaValid), 32'd1);
    check("rd_color", 32'(oVgaColor), 32'd7);
    @(negedge Clock); #1;
    check("rd_valid_drop", 32'(oVgaValid), 32'd0);
    check("rd_color_hold", 32'(oVgaColor), 32'd7);
    $display("txn read (0,0) color=%0d", oVgaColor);

    // free write
    @(negedge Clock); iCpuWrReq = 1'b1; iCpuRow = 8'd5; iCpuCol = 8'd9; iCpuColor = 3'd2; #1;
    check("fw_push_we", 32'(oRamWe), 32'd0);
    @(negedge Clock); iCpuWrReq = 1'b0; #1;
    check("fw_we",   32'(oRamWe),   32'd1);
    check("fw_addr", 32'(oRamAddr), 32'h0509);
    check("fw_data", 32'(oRamData), 32'd2);
    @(negedge Clock); #1;
    check("fw_empty_we", 32'(oRamWe), 32'd0);
    check("fw_ram",      32'(ram[16'h0509]), 32'd2);
    $display("txn write (5,9) color=2");

    // ordering: three pushes drain on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      iCpuWrReq = (i < 3);
      iCpuRow = 8'h01; iCpuCol = 8'(i); iCpuColor = 3'(i + 1);
      #1;
      if (i > 0) begin
        check("ord_we",   32'(oRamWe),   32'd1);
        check("ord_addr", 32'(oRamAddr), 32'h0100 + 32'(i - 1));
        check("ord_data", 32'(oRamData), 32'(i));
        $display("txn ordered write addr=%04h data=%0d", oRamAddr, oRamData);
      end
    end
    iCpuWrReq = 1'b0;
    @(negedge Clock); #1;
    check("ord_done_we", 32'(oRamWe), 32'd0);

    // FIFO full under continuous scanout, starvation-forced write
    for (int k = 0; k < 15; k++) begin
      @(negedge Clock);
      iVgaRdReq = (k <= 10); iVgaRow = 8'h30; iVgaCol = 8'h30;
      iCpuWrReq = (k < 5); iCpuRow = 8'h20; iCpuCol = 8'(k); iCpuColor = 3'(k + 1);
      #1;
      if (k == 3)  check("full_busy_k3",  32'(oCpuBusy), 32'd0);
      if (k == 4)  check("full_busy_k4",  32'(oCpuBusy), 32'd1);
      if (k >= 1 && k <= 8) check("starve_no_we", 32'(oRamWe), 32'd0);
      if (k == 9) begin
        check("forced_we",    32'(oRamWe),    32'd1);
        check("forced_addr",  32'(oRamAddr),  32'h2000);
        check("forced_data",  32'(oRamData),  32'd1);
        check("forced_busy",  32'(oCpuBusy),  32'd1);
        check("pre_valid",    32'(oVgaValid), 32'd1);
      end
      if (k == 10) begin
        check("missed_valid", 32'(oVgaValid), 32'd0);
        check("missed_color", 32'(oVgaColor), 32'd5);
        check("unbusy",       32'(oCpuBusy),  32'd0);
      end
      if (k >= 11 && k <= 13) begin
        check("drain_we",   32'(oRamWe),   32'd1);
        check("drain_addr", 32'(oRamAddr), 32'h2000 + 32'(k - 10));
        check("drain_data", 32'(oRamData), 32'(k - 9));
      end
      if (k == 14) check("dropped_5th", 32'(oRamWe), 32'd0);
      if (oRamWe) $display("txn cycle %0d write addr=%04h data=%0d", k, oRamAddr, oRamData);
    end

    // reset while three writes are queued
    for (int j = 0; j < 3; j++) begin
      @(negedge Clock);
      iVgaRdReq = 1'b1; iCpuWrReq = 1'b1;
      iCpuRow = 8'h40; iCpuCol = 8'(j); iCpuColor = 3'd6;
    end
    @(negedge Clock); Reset = 1'b0; iCpuWrReq = 1'b0; iVgaRdReq = 1'b0; #1;
    check("mid_rst_we", 32'(oRamWe), 32'd0);
    @(negedge Clock); Reset = 1'b1; #1;
    check("post_rst_busy", 32'(oCpuBusy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge Clock); #1;
      check("post_rst_we", 32'(oRamWe), 32'd0);
    end
    check("post_rst_ram", 32'(ram[16'h4000]), 32'd0);
    $display("txn reset mid-drain: queue discarded");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
